dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, default 64; data and address width.
REQ-002 Parameter DEPTH_LOG2, default 10; storage is 2^DEPTH_LOG2 words of 8 bytes.
REQ-003 Parameter LATENCY, default 2, legal 1..15; cycles from request acceptance to rsp_valid.
REQ-004 Parameter BASE_ADDR, default 64'h80000000; byte address of word 0.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  core presents a request.
REQ-008 req_ready  output  1  responder accepts a request this cycle.
REQ-009 req_addr  input  XLEN  byte address (core DmemAddr).
REQ-010 req_wdata  input  XLEN  store data, right-aligned (core DmemDataI).
REQ-011 req_wr  input  1  1 = store, 0 = load (core MemWr).
REQ-012 req_op  input  3  MemOp, RV funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; stores use bits [1:0] only.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  core consumes response.
REQ-015 rsp_rdata  output  XLEN  load result, extended per req_op; 0 for stores.
REQ-016 rsp_err  output  1  access error flag qualified by rsp_valid.

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept = req_valid & req_ready; on accept latch op, wr, byte offset, error status; counter loads LATENCY-1.
REQ-019 Accept with LATENCY=1 -> RESP next cycle; otherwise -> WAIT, counter decrements each cycle, WAIT->RESP when counter==1.
REQ-020 RESP holds rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready=1; then -> IDLE; no new request accepted in the same cycle.
REQ-021 Word index = (req_addr - BASE_ADDR) >> 3, offset = req_addr[2:0].
REQ-022 Out of range (req_addr < BASE_ADDR or >= BASE_ADDR + 8*2^DEPTH_LOG2): rsp_err=1, rsp_rdata=0, no write.
REQ-023 Stores commit in the accept cycle, byte-enabled: B 1, H 2, W 4, D 8 lanes starting at offset; other bytes unchanged.
REQ-024 Loads read the word in the accept cycle; a store and load never overlap because only one request is outstanding.
REQ-025 Load extract: shift word right by 8*offset, take size, sign-extend for 000/001/010, zero-extend for 100/101/110, none for 011.
REQ-026 req_op 111: rsp_err=1, rsp_rdata=0, no write.
REQ-027 rsp_valid and req_ready are never both 1.

Reset
REQ-028 rst=1: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 during the reset cycle, 1 the cycle after release.
REQ-029 Reset mid-WAIT/RESP drops the pending response; a store already committed stays committed.
REQ-030 Storage contents are not cleared by reset.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHECK_EN defined: access with offset not a multiple of its size gives rsp_err=1, rsp_rdata=0, no write.
REQ-032 Macro undefined: offset forced down to natural alignment for the size; misalignment never sets rsp_err.

Verification
REQ-033 SD 0x1122334455667788 @0x80000000, LD same, LATENCY=2 -> rsp_valid 2 cycles after accept, rdata 0x1122334455667788, err 0.
REQ-034 SB 0xAB @0x80000003, then LB and LBU @0x80000003 -> 0xFFFFFFFFFFFFFFAB, 0x00000000000000AB; other bytes of the word unchanged.
REQ-035 Load with rsp_ready=0 for 5 cycles -> rsp_valid and rdata held stable, req_ready 0; rsp_ready=1 -> IDLE next cycle.
REQ-036 LW @0x80000002 -> err=1, rdata 0 with DMEM_MISALIGN_CHECK_EN; without, returns word at 0x80000000, err 0.
REQ-037 SD @0x7FFFFFF8 and @BASE+0x2000 (DEPTH_LOG2=10) -> err=1, storage unchanged.
REQ-038 Assert rst in WAIT -> rsp_valid never rises for that request, req_ready=1 the cycle after rst releases.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Desc     : Single-outstanding data-memory responder for a RISC-V core.
//            It holds 2^DEPTH_LOG2 64-bit words starting at BASE_ADDR.
//            Stores and loads touch storage in the accept cycle. The
//            response appears LATENCY cycles later and is held until the
//            core takes it.
// Config   : define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses as
//            errors. When it is undefined, the offset is rounded down to the
//            natural alignment of the access size.
// Notes    : XLEN must be at most 64.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wr,
  input  logic [2:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned     WORDS    = 1 << DEPTH_LOG2;
  localparam logic [XLEN-1:0] BASE     = BASE_ADDR[XLEN-1:0];
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic [63:0]       mem_q [WORDS];

  logic              accept;
  logic [XLEN-1:0]   rel_addr;
  logic              in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [2:0]        raw_off;
  logic [2:0]        eff_off;
  logic [2:0]        size_mask;
  logic [7:0]        size_be;
  logic [7:0]        lane_be;
  logic              op_bad;
  logic              err_d;
  logic              do_write;
  logic [63:0]       wdata_word;
  logic [63:0]       wdata_lane;
  logic [63:0]       rd_word;
  logic [63:0]       rd_shift;
  logic [63:0]       ext_d;
  logic [63:0]       rdata_d;
  logic              unused_bits;

  // Only one request is ever outstanding, so ready is simply "idle and not in reset".
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // The address decode uses the distance from BASE, which avoids overflow on BASE + size.
  assign rel_addr    = req_addr - BASE;
  assign in_range    = (req_addr >= BASE) && ((rel_addr >> (DEPTH_LOG2 + 3)) == '0);
  assign word_idx    = rel_addr[DEPTH_LOG2+2:3];
  assign raw_off     = req_addr[2:0];
  assign unused_bits = ^rel_addr[2:0];
  assign op_bad      = (req_op == 3'b111);

  // Derive the access size from the low op bits. Stores use only these bits.
  always_comb begin
    size_mask = 3'b000;
    size_be   = 8'h01;
    case (req_op[1:0])
      2'b00:   begin size_mask = 3'b000; size_be = 8'h01; end
      2'b01:   begin size_mask = 3'b001; size_be = 8'h03; end
      2'b10:   begin size_mask = 3'b011; size_be = 8'h0F; end
      default: begin size_mask = 3'b111; size_be = 8'hFF; end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign;
  assign misalign = |(raw_off & size_mask);
  assign eff_off  = raw_off;
  assign err_d    = !in_range || op_bad || misalign;
`else
  assign eff_off  = raw_off & ~size_mask;
  assign err_d    = !in_range || op_bad;
`endif

  // Shift the right-aligned store data and the byte enables up to the byte offset.
  assign wdata_word = 64'(req_wdata);
  assign wdata_lane = wdata_word << {eff_off, 3'b000};
  assign lane_be    = size_be << eff_off;
  assign do_write   = accept && req_wr && !err_d;

  // Extract the load value from the word that is read in the accept cycle.
  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {eff_off, 3'b000};

  // Sign- or zero-extend the shifted word as the op selects.
  always_comb begin
    ext_d = 64'd0;
    case (req_op)
      3'b000:  ext_d = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ext_d = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ext_d = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b011:  ext_d = rd_shift;
      3'b100:  ext_d = {56'd0, rd_shift[7:0]};
      3'b101:  ext_d = {48'd0, rd_shift[15:0]};
      3'b110:  ext_d = {32'd0, rd_shift[31:0]};
      default: ext_d = 64'd0;
    endcase
  end

  assign rdata_d = (err_d || req_wr) ? 64'd0 : ext_d;

  // Byte-enabled storage write. Storage has no reset and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (lane_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

  // Request and response sequencing with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q       <= CNT_LOAD;
            rsp_rdata_q <= rdata_d[XLEN-1:0];
            rsp_err_q   <= err_d;
            if (LATENCY == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Desc     : Self-checking bench for dmem_responder. A byte-level reference
//            memory predicts each response, the driver pushes the prediction
//            into a queue, and a monitor pops and compares each response
//            when the core takes it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        req_wr = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [64:0] sb_q [$];
  logic [64:0] mon_e;
  logic [63:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  dmem_responder #(
    .XLEN      (64),
    .DEPTH_LOG2(10),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wr   (req_wr),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change one time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: predicts the response and applies stores to ref_mem.
  function automatic void model(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                                input logic [63:0] wdata, output logic [63:0] exp_d,
                                output logic exp_e);
    logic [63:0] off;
    logic [63:0] w;
    logic [63:0] v;
    int          sz;
    int          bo;
    int          idx;
    bit          err;
    off = addr - BASE;
    sz  = 1 << op[1:0];
    bo  = int'(addr[2:0]);
    err = (addr < BASE) || (off >= 64'h2000) || (op == 3'b111);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((bo % sz) != 0) err = 1'b1;
`else
    bo = bo - (bo % sz);
`endif
    exp_d = 64'd0;
    exp_e = err;
    if (!err) begin
      idx = int'(off[12:3]);
      if (wr) begin
        for (int i = 0; i < sz; i++) ref_mem[idx][8*(bo+i) +: 8] = wdata[8*i +: 8];
      end else begin
        w = ref_mem[idx];
        v = 64'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(bo+i) +: 8];
        if (!op[2] && sz < 8 && v[8*sz-1]) begin
          for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        exp_d = v;
      end
    end
  endfunction

  // Presents one request and returns after the accept edge with valid dropped.
  task automatic accept(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] exp_d,
                        output logic exp_e, output bit ok);
    int n;
    n = 0;
    exp_d = 64'd0;
    exp_e = 1'b0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    ok = req_ready;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    else model(wr, op, addr, wdata, exp_d, exp_e);
    step();
    req_valid = 1'b0;
  endtask

  // Full transaction. When fx is set, the given constants replace the model's prediction.
  task automatic txn(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                     input logic [63:0] wdata, input int stall, input bit fx,
                     input logic [63:0] fd, input logic fe);
    logic [63:0] ed;
    logic        ee;
    bit          ok;
    int          n;
    accept(wr, op, addr, wdata, ed, ee, ok);
    if (!ok) return;
    if (fx) begin
      ed = fd;
      ee = fe;
    end
    sb_q.push_back({ee, ed});
    rsp_ready = (stall == 0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
    if (!rsp_valid) begin
      rsp_ready = 1'b1;
      return;
    end
    for (int k = 0; k < stall; k++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", rsp_rdata, ed);
      check("hold_err",   64'(rsp_err), 64'(ee));
      check("hold_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("idle_ready", 64'(req_ready), 64'd1);
    check("idle_valid", 64'(rsp_valid), 64'd0);
  endtask

  // Accept a doubleword access, then reset while the response is still pending.
  task automatic rst_in_wait(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
    logic [63:0] ed;
    logic        ee;
    bit          ok;
    accept(wr, 3'b011, addr, wdata, ed, ee, ok);
    rst = 1'b1;
    #1;
    check("rst_ready",  64'(req_ready), 64'd0);
    check("rst_valid",  64'(rsp_valid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check("no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end
  endtask

  // Monitor: compare against the scoreboard whenever a response is consumed.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && req_ready) check("excl", 64'd1, 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rdata", rsp_rdata, mon_e[63:0]);
          check("err", 64'(rsp_err), 64'(mon_e[64]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [63:0] a;
    step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata,      64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    step();
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(req_ready), 64'd1);

    // Doubleword store then load.
    txn(1'b1, 3'b011, BASE, 64'h1122334455667788, 0, 1'b1, 64'd0, 1'b0);
    txn(1'b0, 3'b011, BASE, 64'd0, 0, 1'b1, 64'h1122334455667788, 1'b0);

    // Byte store, then signed and unsigned byte loads, then the full word.
    txn(1'b1, 3'b000, BASE + 64'd3, 64'hAB, 0, 1'b1, 64'd0, 1'b0);
    txn(1'b0, 3'b000, BASE + 64'd3, 64'd0, 0, 1'b1, 64'hFFFFFFFFFFFFFFAB, 1'b0);
    txn(1'b0, 3'b100, BASE + 64'd3, 64'd0, 0, 1'b1, 64'h00000000000000AB, 1'b0);
    txn(1'b0, 3'b011, BASE, 64'd0, 0, 1'b1, 64'h11223344AB667788, 1'b0);

    // Back-pressure for five cycles.
    txn(1'b0, 3'b011, BASE, 64'd0, 5, 1'b0, 64'd0, 1'b0);

    // Misaligned word load.
    txn(1'b0, 3'b010, BASE + 64'd2, 64'd0, 0, 1'b0, 64'd0, 1'b0);

    // Out-of-range stores on both sides, then a store to the last word.
    txn(1'b1, 3'b011, 64'h7FFFFFF8, 64'hDEADBEEFDEADBEEF, 0, 1'b1, 64'd0, 1'b1);
    txn(1'b1, 3'b011, BASE + 64'h2000, 64'hDEADBEEFDEADBEEF, 0, 1'b1, 64'd0, 1'b1);
    txn(1'b0, 3'b011, BASE + 64'h2000, 64'd0, 0, 1'b1, 64'd0, 1'b1);
    txn(1'b1, 3'b011, BASE + 64'h1FF8, 64'h0123456789ABCDEF, 0, 1'b0, 64'd0, 1'b0);
    txn(1'b0, 3'b011, BASE + 64'h1FF8, 64'd0, 0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    txn(1'b0, 3'b011, BASE, 64'd0, 0, 1'b1, 64'h11223344AB667788, 1'b0);

    // Reserved op.
    txn(1'b0, 3'b111, BASE, 64'd0, 0, 1'b1, 64'd0, 1'b1);
    txn(1'b1, 3'b111, BASE, 64'hFFFFFFFFFFFFFFFF, 0, 1'b1, 64'd0, 1'b1);
    txn(1'b0, 3'b011, BASE, 64'd0, 0, 1'b1, 64'h11223344AB667788, 1'b0);

    // Mixed-size stores and loads on one word.
    a = BASE + 64'd128;
    txn(1'b1, 3'b011, a, {$urandom, $urandom}, 0, 1'b0, 64'd0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 3));
      txn(1'b1, op, a + 64'($urandom_range(0, 7)), {$urandom, $urandom}, 0, 1'b0, 64'd0, 1'b0);
      op = 3'($urandom_range(0, 6));
      txn(1'b0, op, a + 64'($urandom_range(0, 7)), 64'd0, 0, 1'b0, 64'd0, 1'b0);
    end
    txn(1'b0, 3'b011, a, 64'd0, 0, 1'b0, 64'd0, 1'b0);

    // Reset mid-flight: the committed store survives, and a pending load is dropped.
    a = BASE + 64'd160;
    txn(1'b1, 3'b011, a, 64'h0F0E0D0C0B0A0908, 0, 1'b0, 64'd0, 1'b0);
    rst_in_wait(1'b1, a, 64'hCAFEF00DCAFEF00D);
    txn(1'b0, 3'b011, a, 64'd0, 0, 1'b1, 64'hCAFEF00DCAFEF00D, 1'b0);
    rst_in_wait(1'b0, a, 64'd0);
    txn(1'b0, 3'b010, a + 64'd4, 64'd0, 0, 1'b1, 64'hFFFFFFFFCAFEF00D, 1'b0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
